// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared definitions for the four-way round-robin arbiter.
//   state_t  : arbiter FSM state encoding
//   NUM_REQ  : number of requesters sharing the resource
//   OWNER_W  : width of the owner / pointer index
package rr_arbiter4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;
  localparam int OWNER_W = 2;

endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requester agents and the arbiter.
//   req       : request vector, bit i = requester i
//   mask      : per-requester disable, a set bit hides the matching req bit
//   gnt       : one-hot grant, zero when no owner
//   gnt_id    : current owner index, qualified by gnt_valid
//   gnt_valid : a grant is held
//   timeout   : one-cycle pulse when a grant is forcibly revoked
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if
  import rr_arbiter4_pkg::*;
  ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] gnt;
  logic [OWNER_W-1:0] gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req, mask,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, mask,
    output gnt, gnt_id, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter4_decoder2to4.sv
// decoder2to4: 2:4 one-hot decoder with enable.
//   sel : 2-bit index
//   en  : when low the output is all-zero
//   dec : one-hot decode of sel
module decoder2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] dec
);

  always_comb begin
    dec = 4'b0000;
    if (en) dec = 4'b0001 << sel;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter sharing one resource among four requesters,
// with a bounded hold time per grant.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_arbiter4_if slave modport (req/mask in, gnt/gnt_id/gnt_valid/timeout out)
// Parameters:
//   HOLD_MAX : maximum consecutive granted cycles, 1..2**CNT_W
//   CNT_W    : hold counter width
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate eff_req starting at ptr
// GRANT | owner holds the resource until release, mask or timeout
module rr_arbiter4
  import rr_arbiter4_pkg::*;
  #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
  ) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter4_if.slave   bus
  );

  // Terminal count of the hold counter: the grant has then been seen for
  // HOLD_MAX cycles, so the next edge revokes it.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t             state;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] owner;
  logic               owner_valid;
  logic [CNT_W-1:0]   hold_cnt;
  logic               timeout_q;

  logic [NUM_REQ-1:0] eff_req;
  logic [OWNER_W-1:0] winner;
  logic               found;
  logic [NUM_REQ-1:0] gnt_dec;

  assign eff_req = bus.req & ~bus.mask;

  // First set bit of eff_req searching ptr, ptr+1, ... ; the index wraps
  // naturally in OWNER_W bits.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eff_req[ptr + OWNER_W'(k)]) begin
        found  = 1'b1;
        winner = ptr + OWNER_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      hold_cnt    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state       <= GRANT;
            owner       <= winner;
            owner_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          // owner is kept on release so gnt_id retains the last owner
          if (!eff_req[owner]) begin
            state       <= IDLE;
            owner_valid <= 1'b0;
            ptr         <= owner + 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= IDLE;
            owner_valid <= 1'b0;
            ptr         <= owner + 1'b1;
            timeout_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  decoder2to4 u_dec (
    .sel (owner),
    .en  (owner_valid),
    .dec (gnt_dec)
  );

  assign bus.gnt       = gnt_dec;
  assign bus.gnt_id    = owner;
  assign bus.gnt_valid = owner_valid;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: two arbiters (HOLD_MAX=8 and HOLD_MAX=1) driven by the same
// directed stimulus, checked every cycle against a behavioural model plus
// hand-computed expectations at key points.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] mask = 4'b0000;

  always #5 clk = ~clk;

  rr_arbiter4_if bus0 ();
  rr_arbiter4_if bus1 ();

  assign bus0.req  = req;
  assign bus0.mask = mask;
  assign bus1.req  = req;
  assign bus1.mask = mask;

  rr_arbiter4 #(.HOLD_MAX(8), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rr_arbiter4 #(.HOLD_MAX(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner = -1 means nobody holds the resource; held counts the
  // cycles the current grant has been visible.
  int hold_max [2] = '{8, 1};
  int m_owner  [2];
  int m_ptr    [2];
  int m_held   [2];
  int m_last   [2];
  bit m_to     [2];

  always @(posedge clk) begin
    logic [3:0] e;
    e = req & ~mask;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_owner[i] = -1;
        m_ptr[i]   = 0;
        m_held[i]  = 0;
        m_last[i]  = 0;
        m_to[i]    = 1'b0;
      end else if (m_owner[i] < 0) begin
        m_to[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          int cand;
          cand = (m_ptr[i] + k) % 4;
          if (m_owner[i] < 0 && e[cand]) m_owner[i] = cand;
        end
        if (m_owner[i] >= 0) begin
          m_held[i] = 1;
          m_last[i] = m_owner[i];
        end
      end else if (!e[m_owner[i]]) begin
        m_ptr[i]   = (m_owner[i] + 1) % 4;
        m_owner[i] = -1;
        m_to[i]    = 1'b0;
      end else if (m_held[i] == hold_max[i]) begin
        m_ptr[i]   = (m_owner[i] + 1) % 4;
        m_owner[i] = -1;
        m_to[i]    = 1'b1;
      end else begin
        m_held[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] a_gnt, e_gnt;
        logic [1:0] a_id;
        logic       a_v, a_to;
        a_gnt = (i == 0) ? bus0.gnt       : bus1.gnt;
        a_id  = (i == 0) ? bus0.gnt_id    : bus1.gnt_id;
        a_v   = (i == 0) ? bus0.gnt_valid : bus1.gnt_valid;
        a_to  = (i == 0) ? bus0.timeout   : bus1.timeout;
        e_gnt = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        chk($sformatf("model d%0d gnt", i), a_gnt, e_gnt);
        chk($sformatf("model d%0d gnt_valid", i), {3'b0, a_v}, {3'b0, m_owner[i] >= 0});
        chk($sformatf("model d%0d timeout", i), {3'b0, a_to}, {3'b0, m_to[i]});
        chk($sformatf("model d%0d gnt_id", i), {2'b0, a_id}, 4'(m_last[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and idle
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t1 gnt", bus0.gnt, 4'b0000);
      chk("t1 gnt_valid", {3'b0, bus0.gnt_valid}, 4'b0000);
      chk("t1 timeout", {3'b0, bus0.timeout}, 4'b0000);
    end

    // requester 1 holds three cycles, then requester 3 wins from ptr=2
    req = 4'b1010;
    tick();
    chk("t2 gnt c1", bus0.gnt, 4'b0010);
    chk("t2 h1 gnt c1", bus1.gnt, 4'b0010);
    tick();
    chk("t2 gnt c2", bus0.gnt, 4'b0010);
    chk("t2 h1 timeout", {3'b0, bus1.timeout}, 4'b0001);
    chk("t2 h1 dead", bus1.gnt, 4'b0000);
    tick();
    chk("t2 gnt c3", bus0.gnt, 4'b0010);
    chk("t2 h1 next", bus1.gnt, 4'b1000);
    req = 4'b1000;
    tick();
    chk("t2 release gnt", bus0.gnt, 4'b0000);
    chk("t2 release timeout", {3'b0, bus0.timeout}, 4'b0000);
    chk("t2 gnt_id kept", {2'b0, bus0.gnt_id}, 4'd1);
    tick();
    chk("t2 next owner", bus0.gnt, 4'b1000);
    req = 4'b0000;
    tick();
    tick();

    // continuous request hits the hold limit
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t3 hold gnt", bus0.gnt, 4'b0001);
    end
    tick();
    chk("t3 revoke gnt", bus0.gnt, 4'b0000);
    chk("t3 timeout", {3'b0, bus0.timeout}, 4'b0001);
    tick();
    chk("t3 regrant", bus0.gnt, 4'b0001);
    chk("t3 timeout clear", {3'b0, bus0.timeout}, 4'b0000);
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // full rotation 0,1,2,3,0, each owner drops after two cycles
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      tick();
      chk("t4 gnt a", bus0.gnt, 4'(1 << g));
      tick();
      chk("t4 gnt b", bus0.gnt, 4'(1 << g));
      req[g] = 1'b0;
      tick();
      chk("t4 dead", bus0.gnt, 4'b0000);
      req[g] = 1'b1;
    end
    req = 4'b0000;
    tick();
    tick();

    // masking the owner acts as a release
    req = 4'b0100;
    tick();
    chk("t5 owner2", bus0.gnt, 4'b0100);
    mask = 4'b0100;
    tick();
    chk("t5 mask gnt", bus0.gnt, 4'b0000);
    chk("t5 mask timeout", {3'b0, bus0.timeout}, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5 masked", bus0.gnt, 4'b0000);
    end
    req = 4'b0110;
    tick();
    chk("t5 other wins", bus0.gnt, 4'b0010);
    req = 4'b0100;
    tick();
    tick();
    chk("t5 still masked", bus0.gnt, 4'b0000);
    mask = 4'b0000;
    tick();
    chk("t5 unmasked", bus0.gnt, 4'b0100);
    req = 4'b0000;
    tick();
    tick();

    // reset in the middle of a grant
    req = 4'b1000;
    tick();
    chk("t6 owner3", bus0.gnt, 4'b1000);
    rst = 1'b1;
    req = 4'b1001;
    tick();
    chk("t6 reset gnt", bus0.gnt, 4'b0000);
    chk("t6 reset timeout", {3'b0, bus0.timeout}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("t6 ptr0 wins", bus0.gnt, 4'b0001);
    req = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
